data_memory_responder: RTL and testbench

Memory-side responder for the core's data port. It accepts one load/store request at a time over a valid/ready request channel and performs a byte-enabled access on word-addressed storage after a configurable number of wait states. It returns the result over a valid/ready response channel. It sits between the core's load/store path and the data RAM, and lets the core be exercised against a multi-cycle data memory.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/data_memory_array.sv | 40 ++++
 rtl/data_memory_responder.sv | 169 ++++++++++++++++
 tb/tb_data_memory_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory responder and its storage array:
//   - mem_state_t  : responder FSM states (IDLE / WAIT / ACCESS / RESPOND)
//   - WAIT_CNT_W   : width of the wait-state down-counter
//   - access_legal : address-window and byte-enable legality check
// The DATA_BEGIN / DATA_END macros normally come from the project config
// include; fallback values are provided so the package compiles stand-alone.
// ---------------------------------------------------------------------------
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h0000_2000
`endif
`ifndef DATA_END
`define DATA_END 32'h0000_3FFF
`endif

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } mem_state_t;

    localparam int unsigned WAIT_CNT_W = 4;

    // An access is legal when the byte address lies inside [lo, hi] and at
    // least one lane is enabled.
    function automatic logic access_legal(input logic [31:0] addr,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi,
                                          input logic [3:0]  be);
        return (addr >= lo) && (addr <= hi) && (be != 4'b0000);
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// ---------------------------------------------------------------------------
// data_memory_array
// Byte-enabled, single-port synchronous RAM with a registered read port.
// The read is read-before-write: q shows the word as it was before a write
// issued on the same edge.
// Ports:
//   clock    - rising-edge clock
//   address  - word address
//   byteena  - per-lane write enables (lane i = data[8i+7:8i])
//   data     - write data
//   wren     - write strobe
//   q        - registered read data for the address of the previous edge
// Storage is deliberately not reset.
// ---------------------------------------------------------------------------
module data_memory_array #(
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [3:0]            byteena,
    input  logic [31:0]           data,
    input  logic                  wren,
    output logic [31:0]           q
);

    logic [31:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

    // Lane-wise write and registered read of the addressed word.
    always_ff @(posedge clock) begin
        if (wren) begin
            for (int i = 0; i < 4; i++) begin
                if (byteena[i]) begin
                    mem_q[address][8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
        q <= mem_q[address];
    end

endmodule

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
// Memory-side responder for the core data port. Accepts one load/store at a
// time, waits WAIT_STATES cycles, performs a byte-enabled access on the word
// storage and returns the pre-access word over a valid/ready response.
// Ports:
//   clock, reset             - clock, synchronous active-low reset
//   req_valid / req_ready    - request handshake
//   req_address, req_byteena,
//   req_wren, req_wdata      - request payload (sampled only at accept)
//   rsp_valid / rsp_ready    - response handshake
//   rsp_rdata, rsp_error     - response payload, stable while in RESPOND
// ---------------------------------------------------------------------------
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES     = 2,
    parameter int unsigned WORD_ADDR_WIDTH = 15,
    parameter logic [31:0] DATA_BEGIN      = `DATA_BEGIN,
    parameter logic [31:0] DATA_END        = `DATA_END
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic [3:0]  req_byteena,
    input  logic        req_wren,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

    mem_state_t                 state_q, state_d;
    logic [WAIT_CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]                addr_q, addr_d;
    logic [3:0]                 byteena_q, byteena_d;
    logic                       wren_q, wren_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [31:0]                rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_error_q, rsp_error_d;

    logic [WORD_ADDR_WIDTH-1:0] ram_addr_s;
    logic                       ram_wren_s;
    logic [31:0]                ram_q_s;
    logic                       legal_s;

    assign legal_s = access_legal(addr_q, DATA_BEGIN, DATA_END, byteena_q);

    // RAM address: in IDLE the live request address is presented so that the
    // registered read is already valid in ACCESS even with zero wait states.
    always_comb begin
        ram_addr_s = addr_q[WORD_ADDR_WIDTH+1:2];
        if (state_q == IDLE) begin
            ram_addr_s = req_address[WORD_ADDR_WIDTH+1:2];
        end else begin
            ram_addr_s = addr_q[WORD_ADDR_WIDTH+1:2];
        end
    end

    // Next-state and datapath control for the request/response FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        byteena_d   = byteena_q;
        wren_d      = wren_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        ram_wren_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_address;
                    byteena_d = req_byteena;
                    wren_d    = req_wren;
                    wdata_d   = req_wdata;
                    cnt_d     = WAIT_LOAD;
                    if (WAIT_LOAD != '0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // <= rather than == so a corrupted zero count cannot stall.
                if (cnt_q <= CNT_ONE) begin
                    state_d = ACCESS;
                end else begin
                    state_d = WAIT;
                end
            end
            ACCESS: begin
                // ram_q_s holds the pre-write word; the write lands on this edge.
                ram_wren_s = wren_q && legal_s && reset;
                cnt_d      = '0;
                if (legal_s) begin
                    rsp_rdata_d = ram_q_s;
                    rsp_error_d = 1'b0;
                end else begin
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_error_d = 1'b1;
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESPOND;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and request/response registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= 32'h0000_0000;
            byteena_q   <= 4'b0000;
            wren_q      <= 1'b0;
            wdata_q     <= 32'h0000_0000;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            byteena_q   <= byteena_d;
            wren_q      <= wren_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESPOND);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    data_memory_array #(
        .ADDR_WIDTH (WORD_ADDR_WIDTH)
    ) u_array (
        .clock   (clock),
        .address (ram_addr_s),
        .byteena (byteena_q),
        .data    (wdata_q),
        .wren    (ram_wren_s),
        .q       (ram_q_s)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
// Directed bench: one responder with WAIT_STATES=2 (u_dut) and one with
// WAIT_STATES=0 (u_dut0), window 0x2000..0x3FFF.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

    localparam logic [31:0] DB = 32'h0000_2000;
    localparam logic [31:0] DE = 32'h0000_3FFF;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;

    // DUT with two wait states
    logic        req_valid, req_ready, req_wren, rsp_valid, rsp_ready, rsp_error;
    logic [31:0] req_address, req_wdata, rsp_rdata;
    logic [3:0]  req_byteena;

    // DUT with zero wait states
    logic        req_valid0, req_ready0, req_wren0, rsp_valid0, rsp_ready0, rsp_error0;
    logic [31:0] req_address0, req_wdata0, rsp_rdata0;
    logic [3:0]  req_byteena0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder #(
        .WAIT_STATES(2), .WORD_ADDR_WIDTH(15), .DATA_BEGIN(DB), .DATA_END(DE)
    ) u_dut (
        .clock(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
        .req_byteena(req_byteena), .req_wren(req_wren), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    data_memory_responder #(
        .WAIT_STATES(0), .WORD_ADDR_WIDTH(15), .DATA_BEGIN(DB), .DATA_END(DE)
    ) u_dut0 (
        .clock(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_address(req_address0),
        .req_byteena(req_byteena0), .req_wren(req_wren0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .rsp_error(rsp_error0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for rsp_valid after an accept edge, then complete the
    // handshake with rsp_ready (assumed 1). Called at #1 after the accept edge.
    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) break;
        end
        rd = rsp_rdata;
        er = rsp_error;
        @(posedge clk); #1;
    endtask

    // One complete transaction on u_dut; request inputs are scrambled right
    // after the accept edge.
    task automatic xact(input string tag, input logic [31:0] addr, input logic [3:0] be,
                        input logic wr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_address = addr; req_byteena = be;
        req_wren = wr; req_wdata = wd;
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_address = ~addr; req_byteena = ~be;
        req_wren = ~wr; req_wdata = ~wd;
        wait_rsp(lat, rd, er);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    int          acc [3];

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_address = 32'd0; req_byteena = 4'd0; req_wren = 1'b0;
        req_wdata = 32'd0; rsp_ready = 1'b1;
        req_valid0 = 1'b0; req_address0 = 32'd0; req_byteena0 = 4'd0; req_wren0 = 1'b0;
        req_wdata0 = 32'd0; rsp_ready0 = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_valid",  {31'd0, rsp_valid},  32'd0);
        chk("rst_rdata",  rsp_rdata,           32'd0);
        chk("rst_error",  {31'd0, rsp_error},  32'd0);
        chk("rst0_ready", {31'd0, req_ready0}, 32'd1);
        chk("rst0_valid", {31'd0, rsp_valid0}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Word store then load
        xact("st1", DB, 4'b1111, 1'b1, 32'hDEAD_BEEF, rd, er, lat);
        chk("st1_lat", 32'(lat), 32'd3);
        chk("st1_err", {31'd0, er}, 32'd0);
        xact("ld1", DB, 4'b1111, 1'b0, 32'h0, rd, er, lat);
        chk("ld1_lat",   32'(lat), 32'd3);
        chk("ld1_rdata", rd, 32'hDEAD_BEEF);
        chk("ld1_err",   {31'd0, er}, 32'd0);

        // Byte store returns the pre-write word
        xact("st2", DB + 32'd2, 4'b0100, 1'b1, 32'h00AA_0000, rd, er, lat);
        chk("st2_rdata", rd, 32'hDEAD_BEEF);
        chk("st2_err",   {31'd0, er}, 32'd0);
        xact("ld2", DB, 4'b1111, 1'b0, 32'h0, rd, er, lat);
        chk("ld2_rdata", rd, 32'hDEAA_BEEF);

        // Out of range and window boundaries
        xact("ld_oor", DE + 32'd1, 4'b1111, 1'b0, 32'h0, rd, er, lat);
        chk("ld_oor_lat",   32'(lat), 32'd3);
        chk("ld_oor_err",   {31'd0, er}, 32'd1);
        chk("ld_oor_rdata", rd, 32'd0);
        xact("st_end", DE - 32'd3, 4'b1111, 1'b1, 32'h0BAD_F00D, rd, er, lat);
        chk("st_end_err", {31'd0, er}, 32'd0);
        xact("ld_end", DE, 4'b1111, 1'b0, 32'h0, rd, er, lat);
        chk("ld_end_rdata", rd, 32'h0BAD_F00D);
        chk("ld_end_err",   {31'd0, er}, 32'd0);
        xact("st_oor", DE + 32'd1, 4'b1111, 1'b1, 32'hFFFF_FFFF, rd, er, lat);
        chk("st_oor_err",   {31'd0, er}, 32'd1);
        chk("st_oor_rdata", rd, 32'd0);
        xact("ld_end2", DE, 4'b1111, 1'b0, 32'h0, rd, er, lat);
        chk("ld_end2_rdata", rd, 32'h0BAD_F00D);
        xact("ld_beg2", DB, 4'b1111, 1'b0, 32'h0, rd, er, lat);
        chk("ld_beg2_rdata", rd, 32'hDEAA_BEEF);
        xact("ld_hi", DB | 32'h8000_0000, 4'b1111, 1'b0, 32'h0, rd, er, lat);
        chk("ld_hi_err",   {31'd0, er}, 32'd1);
        chk("ld_hi_rdata", rd, 32'd0);
        xact("ld_be0", DB, 4'b0000, 1'b0, 32'h0, rd, er, lat);
        chk("ld_be0_err",   {31'd0, er}, 32'd1);
        chk("ld_be0_rdata", rd, 32'd0);

        // Backpressure: hold rsp_ready low for 5 cycles with a request waiting
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_address = DB; req_byteena = 4'b1111; req_wren = 1'b0;
        req_wdata = 32'd0;
        chk("bp_ready0", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) break;
        end
        chk("bp_lat", 32'(lat), 32'd3);
        req_valid = 1'b1; req_address = DB + 32'd8; req_byteena = 4'b1111;
        req_wren = 1'b1; req_wdata = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hDEAA_BEEF);
            chk("bp_err",   {31'd0, rsp_error}, 32'd0);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_rel_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("bp_acc_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        wait_rsp(lat, rd, er);
        chk("bp_st_lat", 32'(lat), 32'd3);
        chk("bp_st_err", {31'd0, er}, 32'd0);
        xact("bp_ld", DB + 32'd8, 4'b1111, 1'b0, 32'h0, rd, er, lat);
        chk("bp_ld_rdata", rd, 32'h0000_0055);

        // Reset during WAIT of a store
        @(negedge clk);
        req_valid = 1'b1; req_address = DB; req_byteena = 4'b1111; req_wren = 1'b1;
        req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mr_inwait_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mr_ready", {31'd0, req_ready}, 32'd1);
        chk("mr_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mr_rdata", rsp_rdata, 32'd0);
        chk("mr_err",   {31'd0, rsp_error}, 32'd0);
        reset = 1'b1;
        xact("mr_ld", DB, 4'b1111, 1'b0, 32'h0, rd, er, lat);
        chk("mr_ld_rdata", rd, 32'hDEAA_BEEF);

        // Zero wait states: store then two loads with req_valid held high
        @(negedge clk);
        req_valid0 = 1'b1; req_address0 = DB + 32'd4; req_byteena0 = 4'b1111;
        req_wren0 = 1'b1; req_wdata0 = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!req_ready0 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("w0_ready", {31'd0, req_ready0}, 32'd1);
            @(posedge clk); #1;
            acc[k] = cyc;
            chk("w0_noval", {31'd0, rsp_valid0}, 32'd0);
            req_wren0 = 1'b0;
            req_wdata0 = 32'h0;
            if (k == 2) req_valid0 = 1'b0;
            @(posedge clk); #1;
            chk("w0_valid", {31'd0, rsp_valid0}, 32'd1);
            chk("w0_err",   {31'd0, rsp_error0}, 32'd0);
            if (k > 0) begin
                chk("w0_rdata",   rsp_rdata0, 32'hCAFE_F00D);
                chk("w0_spacing", 32'(acc[k] - acc[k-1]), 32'd3);
            end
        end
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
